// File: rtl/tnoc_flit_port_arbiter_pkg.sv
// tnoc_pkg: arbiter state type, index type and round-robin winner search.
// Shared by tnoc_flit_port_arbiter and its bench.
package tnoc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } tnoc_arb_state_e;

  localparam int MAX_ENTRIES = 16;
  localparam int IDX_W = 4;

  typedef logic [IDX_W-1:0] tnoc_idx_t;

  // First set request at or after ptr, wrapping within n entries.
  function automatic tnoc_idx_t rr_winner(
    input logic [MAX_ENTRIES-1:0] req,
    input tnoc_idx_t ptr,
    input int n
  );
    tnoc_idx_t w;
    logic found;
    int idx;
    w = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_ENTRIES; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!found && k < n && req[idx[3:0]]) begin
        w = idx[3:0];
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/tnoc_flit_port_arbiter_if.sv
// Flit arbiter bus: ENTRIES requester ports plus one shared output port.
// master = requester/downstream side, slave = arbiter.
interface tnoc_flit_port_arbiter_if #(
  parameter int ENTRIES = 4,
  parameter int FLIT_WIDTH = 64
);
  logic [ENTRIES-1:0]            i_entry_enable;
  logic [ENTRIES-1:0]            i_valid;
  logic [ENTRIES-1:0]            o_ready;
  logic [ENTRIES*FLIT_WIDTH-1:0] i_flit;
  logic [ENTRIES-1:0]            i_tail;
  logic                          o_valid;
  logic                          i_ready;
  logic [FLIT_WIDTH-1:0]         o_flit;
  logic                          o_tail;
  logic [ENTRIES-1:0]            o_grant;

  modport master (
    output i_entry_enable, i_valid, i_flit,
    output i_tail, i_ready,
    input  o_ready, o_valid, o_flit,
    input  o_tail, o_grant
  );

  modport slave (
    input  i_entry_enable, i_valid, i_flit,
    input  i_tail, i_ready,
    output o_ready, o_valid, o_flit,
    output o_tail, o_grant
  );
endinterface

// File: rtl/tnoc_flit_port_arbiter_skid_buffer.sv
// tnoc_flit_skid_buffer: 2-entry register FIFO, ready = not full.
// Ports: in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module tnoc_flit_skid_buffer #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] mem [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tnoc_flit_port_arbiter.sv
// Packet-locked round-robin arbiter sharing one flit port among ENTRIES.
// Ports: clk, rst (sync, high), bus (slave). TNOC_FLIT_PORT_ARBITER_OUTPUT_REG_EN adds skid stage.
module tnoc_flit_port_arbiter
  import tnoc_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int FLIT_WIDTH = 64
) (
  input logic clk,
  input logic rst,
  tnoc_flit_port_arbiter_if.slave bus
);
  tnoc_arb_state_e       state;
  tnoc_idx_t             rr_ptr;
  tnoc_idx_t             owner;
  tnoc_idx_t             winner;
  tnoc_idx_t             cur;
  tnoc_idx_t             ptr_next;
  logic [ENTRIES-1:0]    req;
  logic [ENTRIES-1:0]    sel;
  logic                  active;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_tail;
  logic [FLIT_WIDTH-1:0] in_flit;
  logic                  xfer;

  assign req    = bus.i_valid & bus.i_entry_enable;
  assign winner = rr_winner(MAX_ENTRIES'(req), rr_ptr, ENTRIES);
  assign cur    = (state == LOCKED) ? owner : winner;
  assign active = (state == LOCKED) || (|req);

  assign ptr_next = (cur == IDX_W'(ENTRIES-1)) ? '0 : cur + 1'b1;

  always_comb begin
    sel     = '0;
    in_flit = '0;
    in_tail = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (active && cur == IDX_W'(i)) begin
        sel[i] = 1'b1;
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel[i]) begin
        in_flit = bus.i_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        in_tail = bus.i_tail[i];
      end
    end
  end

  assign in_valid    = |(sel & bus.i_valid);
  assign bus.o_grant = sel;
  assign bus.o_ready = sel & {ENTRIES{in_ready}};
  assign xfer        = in_valid & in_ready;

`ifdef TNOC_FLIT_PORT_ARBITER_OUTPUT_REG_EN
  logic [FLIT_WIDTH:0] out_data;
  logic                out_valid;

  tnoc_flit_skid_buffer #(
    .WIDTH (FLIT_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_tail, in_flit}),
    .out_valid (out_valid),
    .out_ready (bus.i_ready),
    .out_data  (out_data)
  );

  assign bus.o_valid = out_valid;
  assign bus.o_tail  = out_data[FLIT_WIDTH];
  assign bus.o_flit  = out_data[FLIT_WIDTH-1:0];
`else
  assign in_ready    = bus.i_ready;
  assign bus.o_valid = in_valid;
  assign bus.o_tail  = in_tail;
  assign bus.o_flit  = in_flit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            if (in_tail) begin
              rr_ptr <= ptr_next;
            end else begin
              state <= LOCKED;
              owner <= winner;
            end
          end
        end
        LOCKED: begin
          if (xfer && in_tail) begin
            state  <= IDLE;
            rr_ptr <= ptr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tnoc_flit_port_arbiter.sv
// Bench for tnoc_flit_port_arbiter: directed packet tests plus random
// traffic, checked each cycle against a packet-level arbitration model.
module tb_tnoc_flit_port_arbiter;
  import tnoc_pkg::*;

  localparam int N = 4;
  localparam int W = 64;

  typedef struct {
    logic         tail;
    logic [W-1:0] data;
  } flit_t;

  typedef struct {
    int           idx;
    logic         tail;
    logic [W-1:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tnoc_flit_port_arbiter_if #(
    .ENTRIES    (N),
    .FLIT_WIDTH (W)
  ) bus ();

  tnoc_flit_port_arbiter #(
    .ENTRIES    (N),
    .FLIT_WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  flit_t      q [N][$];
  flit_t      sent [N][$];
  rec_t       log_q [$];
  int         exp_q [$];
  logic [N-1:0] hold;
  logic [N-1:0] en;
  logic       rdy;
  int         m_ptr;
  int         m_owner;
  bit         m_lock;
  int         total = 0;
  int         bad = 0;
  int         vcnt;
  int         r2cnt;
  logic       prev_v;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Packet-level arbitration rule: locked owner, else the first
  // requester at or after the pointer, wrapping around.
  function automatic int model_pick(logic [N-1:0] rq);
    if (m_lock) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic push_pkt(int e, int len);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.tail = (i == len - 1);
      f.data = {$urandom, $urandom};
      q[e].push_back(f);
      sent[e].push_back(f);
    end
  endtask

  task automatic step();
    logic [N-1:0]   v;
    logic [N-1:0]   t;
    logic [N*W-1:0] f;
    logic [N-1:0]   eg;
    logic           ev;
    int             g;
    rec_t           r;
    v = '0;
    t = '0;
    f = '0;
    for (int e = 0; e < N; e++) begin
      if (q[e].size() != 0) begin
        v[e] = !hold[e];
        t[e] = q[e][0].tail;
        f[e*W +: W] = q[e][0].data;
      end
    end
    bus.i_valid        = v;
    bus.i_tail         = t;
    bus.i_flit         = f;
    bus.i_entry_enable = en;
    bus.i_ready        = rdy;
    g  = model_pick(v & en);
    eg = (g >= 0) ? (N'(1) << g) : '0;
    ev = (g >= 0) ? v[g] : 1'b0;
    @(negedge clk);
    prev_v = bus.o_valid;
    chk("grant", 64'(bus.o_grant), 64'(eg));
    chk("ready", 64'(bus.o_ready), 64'(rdy ? eg : '0));
    chk("valid", 64'(bus.o_valid), 64'(ev));
    if (ev) begin
      chk("flit", bus.o_flit, f[g*W +: W]);
      chk("tail", 64'(bus.o_tail), 64'(t[g]));
    end
    if (ev && rdy && !rst) begin
      r.idx  = g;
      r.tail = t[g];
      r.data = f[g*W +: W];
      log_q.push_back(r);
    end
    @(posedge clk);
    if (rst) begin
      m_lock  = 1'b0;
      m_ptr   = 0;
      m_owner = 0;
    end else if (ev && rdy) begin
      void'(q[g].pop_front());
      if (t[g]) begin
        m_lock = 1'b0;
        m_ptr  = (g + 1) % N;
      end else begin
        m_lock  = 1'b1;
        m_owner = g;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int e = 0; e < N; e++) begin
      q[e].delete();
      sent[e].delete();
    end
    log_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic run_drain(int budget);
    int busy;
    for (int c = 0; c < budget; c++) begin
      busy = 0;
      for (int e = 0; e < N; e++) busy += q[e].size();
      if (busy == 0) break;
      step();
    end
    busy = 0;
    for (int e = 0; e < N; e++) busy += q[e].size();
    chk("drain_timeout", 64'(busy), 64'd0);
  endtask

  // Per-entry data order and no packet interleaving on the output.
  task automatic verify_log(string tag, bit drained);
    flit_t s;
    int    viol;
    int    left;
    viol = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (i > 0 && !log_q[i-1].tail &&
          log_q[i].idx != log_q[i-1].idx) viol++;
      if (sent[log_q[i].idx].size() == 0) begin
        viol++;
      end else begin
        s = sent[log_q[i].idx].pop_front();
        if (s.data !== log_q[i].data) viol++;
        if (s.tail !== log_q[i].tail) viol++;
      end
    end
    chk({tag, "_order"}, 64'(viol), 64'd0);
    if (drained) begin
      left = 0;
      for (int e = 0; e < N; e++) left += sent[e].size();
      chk({tag, "_left"}, 64'(left), 64'd0);
    end
  endtask

  task automatic check_idx(string tag);
    chk({tag, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) begin
        chk(tag, 64'(log_q[i].idx), 64'(exp_q[i]));
      end
    end
  endtask

  initial begin
    hold = '0;
    en   = '1;
    rdy  = 1'b1;
    rst  = 1'b1;
    m_lock = 1'b0;
    m_ptr = 0;
    m_owner = 0;
    bus.i_valid = '0;
    bus.i_tail = '0;
    bus.i_flit = '0;
    bus.i_entry_enable = '1;
    bus.i_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_grant", 64'(bus.o_grant), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);

    // Test 1: two 3-flit packets, entry 0 then entry 2
    push_pkt(0, 3);
    push_pkt(2, 3);
    run_drain(20);
    exp_q = '{0, 0, 0, 2, 2, 2};
    check_idx("t1_idx");
    verify_log("t1", 1'b1);

    // Test 2: single-flit packets from everyone
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int e = 0; e < N; e++) push_pkt(e, 1);
    end
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (prev_v) vcnt++;
    end
    chk("t2_vcnt", 64'(vcnt), 64'd8);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_idx("t2_idx");
    verify_log("t2", 1'b1);

    // Test 3: entry 2 disabled
    do_reset();
    en = 4'b1011;
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < N; e++) push_pkt(e, 1);
    end
    r2cnt = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      if (bus.o_ready[2]) r2cnt++;
    end
    chk("t3_ready2", 64'(r2cnt), 64'd0);
    exp_q = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
    check_idx("t3_idx");
    sent[2].delete();
    q[2].delete();
    verify_log("t3", 1'b1);
    en = '1;

    // Test 4: owner stalls mid-packet while entry 1 waits
    do_reset();
    push_pkt(0, 3);
    push_pkt(1, 1);
    step();
    hold = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t4_stall_v", 64'(prev_v), 64'd0);
      chk("t4_stall_g", 64'(bus.o_grant), 64'd1);
    end
    hold = '0;
    run_drain(20);
    exp_q = '{0, 0, 0, 1};
    check_idx("t4_idx");
    verify_log("t4", 1'b1);

    // Test 5: downstream ready toggling over a 4-flit packet
    do_reset();
    push_pkt(0, 4);
    for (int c = 0; c < 20; c++) begin
      rdy = (c % 2 == 0);
      if (q[0].size() != 0) step();
    end
    rdy = 1'b1;
    chk("t5_left", 64'(q[0].size()), 64'd0);
    exp_q = '{0, 0, 0, 0};
    check_idx("t5_idx");
    verify_log("t5", 1'b1);

    // Test 6: reset after the 2nd flit abandons the packet
    do_reset();
    push_pkt(1, 4);
    step();
    step();
    verify_log("t6a", 1'b0);
    q[1].delete();
    sent[1].delete();
    log_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_state", 64'(dut.state), 64'(IDLE));
    chk("t6_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("t6_valid", 64'(bus.o_valid), 64'd0);
    push_pkt(3, 1);
    run_drain(10);
    exp_q = '{3};
    check_idx("t6_idx");
    verify_log("t6", 1'b1);

    // Random traffic
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int e = 0; e < N; e++) begin
        if (q[e].size() == 0 && $urandom_range(0, 2) == 0)
          push_pkt(e, $urandom_range(1, 4));
      end
      hold = N'($urandom) & N'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      step();
    end
    hold = '0;
    rdy  = 1'b1;
    run_drain(100);
    verify_log("rand", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
